sii_l2t_pkt_tracker: RTL

// Parametrised SII->L2T inbound packet tracker: replaces fixed per-bank print logic with synthesizable capture.

---
 rtl/sii_l2t_trk_pkg.sv | 25 ++
 rtl/sii_l2t_trk_ch.sv | 161 ++++++++++++++++
 rtl/sii_l2t_pkt_tracker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sii_l2t_trk_pkg.sv
// Shared types for the SII->L2T packet tracker.
//   trk_state_e : per-bank capture FSM state
//   *_HI/*_LO   : header field bit positions within a 32-bit request word
//   trk_rec_t   : one decoded packet record (opes, cfg, tag, 40-bit address)
package sii_l2t_trk_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, SKIP} trk_state_e;

  localparam int OPES_HI    = 30;
  localparam int OPES_LO    = 27;
  localparam int CFG_HI     = 26;
  localparam int CFG_LO     = 24;
  localparam int TAG_HI     = 21;
  localparam int TAG_LO     = 8;
  localparam int ADDR_HI_HI = 7;
  localparam int ADDR_HI_LO = 0;

  typedef struct packed {
    logic [3:0]  opes;
    logic [2:0]  cfg;
    logic [13:0] tag;
    logic [39:0] addr;
  } trk_rec_t;

endpackage

// File: rtl/sii_l2t_trk_ch.sv
// Per-bank tracker: header capture FSM, one-entry holding register and
// saturating IQ / WIB outstanding counters with sticky error flags.
//   req/req_vld      : bank request word, header-cycle strobe
//   iq_dequeue       : L2T dequeued one IQ entry
//   wib_dequeue      : L2T drained one WRI line
//   pop              : arbiter consumed this bank's holding register
//   hold_vld/rec     : holding register contents
//   iq_cnt           : outstanding IQ entries
//   err_*            : sticky protocol / overflow / underflow flags
module sii_l2t_trk_ch
  import sii_l2t_trk_pkg::*;
#(
  parameter int         REQ_W     = 32,
  parameter int         IQ_DEPTH  = 16,
  parameter int         WIB_DEPTH = 4,
  parameter int         SKIP_CYC  = 3,
  parameter logic [3:0] WRI_OPES  = 4'b0010,
  parameter int         CW        = $clog2(IQ_DEPTH + 1)
) (
  input  logic             iol2clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] req,
  input  logic             req_vld,
  input  logic             iq_dequeue,
  input  logic             wib_dequeue,
  input  logic             pop,
  output logic             hold_vld,
  output trk_rec_t         hold_rec,
  output logic [CW-1:0]    iq_cnt,
  output logic             err_proto,
  output logic             err_rec_ovf,
  output logic             err_iq_ovf,
  output logic             err_iq_unf,
  output logic             err_wib_ovf,
  output logic             err_wib_unf
);

  localparam int WW = $clog2(WIB_DEPTH + 1);
  localparam int SW = (SKIP_CYC > 1) ? $clog2(SKIP_CYC) : 1;

  trk_state_e  state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [3:0]  opes_q, opes_d;
  logic [2:0]  cfg_q, cfg_d;
  logic [13:0] tag_q, tag_d;
  logic [7:0]  ahi_q, ahi_d;
  logic        hold_vld_q, hold_vld_d;
  trk_rec_t    hold_q, hold_d;
  logic [CW-1:0] iq_q, iq_d;
  logic [WW-1:0] wib_q, wib_d;
  logic [5:0]  err_q, err_d;   // {wib_unf, wib_ovf, iq_unf, iq_ovf, rec_ovf, proto}
  logic        cmpl, iq_inc, wib_inc;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    opes_d     = opes_q;
    cfg_d      = cfg_q;
    tag_d      = tag_q;
    ahi_d      = ahi_q;
    hold_vld_d = hold_vld_q & ~pop;
    hold_d     = hold_q;
    iq_d       = iq_q;
    wib_d      = wib_q;
    err_d      = err_q;
    cmpl       = 1'b0;
    iq_inc     = 1'b0;
    wib_inc    = 1'b0;

    case (state_q)
      IDLE: if (req_vld) begin
        state_d = ADDR;
        opes_d  = req[OPES_HI:OPES_LO];
        cfg_d   = req[CFG_HI:CFG_LO];
        tag_d   = req[TAG_HI:TAG_LO];
        ahi_d   = req[ADDR_HI_HI:ADDR_HI_LO];
        iq_inc  = 1'b1;
      end
      ADDR: begin
        cmpl    = 1'b1;
        wib_inc = (opes_q == WRI_OPES);
        state_d = SKIP;
        skip_d  = SW'(SKIP_CYC - 1);
      end
      SKIP: begin
        if (skip_q == '0) state_d = IDLE;
        else              skip_d  = skip_q - SW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A header strobe mid-packet is flagged and otherwise ignored.
    if (req_vld && state_q != IDLE) err_d[0] = 1'b1;

    // The slot frees on the same edge it is popped, so a completion that
    // coincides with the pop is accepted rather than dropped.
    if (cmpl) begin
      if (hold_vld_q && !pop) begin
        err_d[1] = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = '{opes: opes_q, cfg: cfg_q, tag: tag_q, addr: {ahi_q, req[31:0]}};
      end
    end

    if (iq_inc && !iq_dequeue) begin
      if (iq_q == CW'(IQ_DEPTH)) err_d[2] = 1'b1;
      else                       iq_d = iq_q + CW'(1);
    end else if (!iq_inc && iq_dequeue) begin
      if (iq_q == '0) err_d[3] = 1'b1;
      else            iq_d = iq_q - CW'(1);
    end

    if (wib_inc && !wib_dequeue) begin
      if (wib_q == WW'(WIB_DEPTH)) err_d[4] = 1'b1;
      else                         wib_d = wib_q + WW'(1);
    end else if (!wib_inc && wib_dequeue) begin
      if (wib_q == '0) err_d[5] = 1'b1;
      else             wib_d = wib_q - WW'(1);
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      opes_q     <= '0;
      cfg_q      <= '0;
      tag_q      <= '0;
      ahi_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      iq_q       <= '0;
      wib_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      opes_q     <= opes_d;
      cfg_q      <= cfg_d;
      tag_q      <= tag_d;
      ahi_q      <= ahi_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      iq_q       <= iq_d;
      wib_q      <= wib_d;
      err_q      <= err_d;
    end
  end

  assign hold_vld    = hold_vld_q;
  assign hold_rec    = hold_q;
  assign iq_cnt      = iq_q;
  assign err_proto   = err_q[0];
  assign err_rec_ovf = err_q[1];
  assign err_iq_ovf  = err_q[2];
  assign err_iq_unf  = err_q[3];
  assign err_wib_ovf = err_q[4];
  assign err_wib_unf = err_q[5];

endmodule

// File: rtl/sii_l2t_pkt_tracker.sv
// SII->L2T inbound packet tracker top.
// One sii_l2t_trk_ch per bank decodes packets into holding registers; a
// round-robin arbiter copies one holding register at a time into the
// registered rec_* ready/valid output. A bank's holding register stays
// occupied until its record is accepted downstream.
//   iol2clk/rst          : clock, synchronous active-high reset
//   req/req_vld          : per-bank request words and header strobes
//   iq_dequeue/wib_dequeue : per-bank credit returns
//   rec_*                : record stream (rec_vld/rec_rdy handshake)
//   iq_cnt               : per-bank outstanding IQ count, CW bits each
//   err_*                : per-bank sticky error flags
module sii_l2t_pkt_tracker
  import sii_l2t_trk_pkg::*;
#(
  parameter int         NUM_CH    = 8,
  parameter int         REQ_W     = 32,
  parameter int         IQ_DEPTH  = 16,
  parameter int         WIB_DEPTH = 4,
  parameter int         SKIP_CYC  = 3,
  parameter logic [3:0] WRI_OPES  = 4'b0010
) (
  input  logic                                        iol2clk,
  input  logic                                        rst,
  input  logic [NUM_CH*REQ_W-1:0]                     req,
  input  logic [NUM_CH-1:0]                           req_vld,
  input  logic [NUM_CH-1:0]                           iq_dequeue,
  input  logic [NUM_CH-1:0]                           wib_dequeue,
  output logic                                        rec_vld,
  input  logic                                        rec_rdy,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rec_ch,
  output logic [3:0]                                  rec_opes,
  output logic [2:0]                                  rec_cfg,
  output logic [13:0]                                 rec_tag,
  output logic [39:0]                                 rec_addr,
  output logic [NUM_CH*$clog2(IQ_DEPTH+1)-1:0]        iq_cnt,
  output logic [NUM_CH-1:0]                           err_proto,
  output logic [NUM_CH-1:0]                           err_rec_ovf,
  output logic [NUM_CH-1:0]                           err_iq_ovf,
  output logic [NUM_CH-1:0]                           err_iq_unf,
  output logic [NUM_CH-1:0]                           err_wib_ovf,
  output logic [NUM_CH-1:0]                           err_wib_unf
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(IQ_DEPTH + 1);

  logic [NUM_CH-1:0]         hold_vld, pop, elig;
  trk_rec_t [NUM_CH-1:0]     hold_rec;
  logic [NUM_CH-1:0][CW-1:0] iq_cnt_a;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sii_l2t_trk_ch #(
      .REQ_W(REQ_W), .IQ_DEPTH(IQ_DEPTH), .WIB_DEPTH(WIB_DEPTH),
      .SKIP_CYC(SKIP_CYC), .WRI_OPES(WRI_OPES), .CW(CW)
    ) u_ch (
      .iol2clk     (iol2clk),
      .rst         (rst),
      .req         (req[g*REQ_W +: REQ_W]),
      .req_vld     (req_vld[g]),
      .iq_dequeue  (iq_dequeue[g]),
      .wib_dequeue (wib_dequeue[g]),
      .pop         (pop[g]),
      .hold_vld    (hold_vld[g]),
      .hold_rec    (hold_rec[g]),
      .iq_cnt      (iq_cnt_a[g]),
      .err_proto   (err_proto[g]),
      .err_rec_ovf (err_rec_ovf[g]),
      .err_iq_ovf  (err_iq_ovf[g]),
      .err_iq_unf  (err_iq_unf[g]),
      .err_wib_ovf (err_wib_ovf[g]),
      .err_wib_unf (err_wib_unf[g])
    );
  end

  assign iq_cnt = iq_cnt_a;

  logic           rec_vld_q, rec_vld_d;
  logic [CHW-1:0] rec_ch_q, rec_ch_d;
  trk_rec_t       rec_q, rec_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic           accept, load, found;
  logic [CHW-1:0] win;
  int             idx;

  assign accept = rec_vld_q & rec_rdy;
  assign pop    = accept ? (NUM_CH'(1) << rec_ch_q) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    rec_vld_d = rec_vld_q;
    rec_ch_d  = rec_ch_q;
    rec_d     = rec_q;
    found     = 1'b0;
    win       = '0;
    idx       = 0;

    if (accept) ptr_d = (rec_ch_q == CHW'(NUM_CH - 1)) ? '0 : rec_ch_q + CHW'(1);

    // The bank currently on the output is still marked full; keep it out
    // of the next search so a record is never presented twice.
    elig = hold_vld;
    if (rec_vld_q) elig[rec_ch_q] = 1'b0;

    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_d) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CHW'(idx);
      end
    end

    load = !rec_vld_q || rec_rdy;
    if (load) begin
      rec_vld_d = found;
      if (found) begin
        rec_ch_d = win;
        rec_d    = hold_rec[win];
      end
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      rec_vld_q <= 1'b0;
      rec_ch_q  <= '0;
      rec_q     <= '0;
      ptr_q     <= '0;
    end else begin
      rec_vld_q <= rec_vld_d;
      rec_ch_q  <= rec_ch_d;
      rec_q     <= rec_d;
      ptr_q     <= ptr_d;
    end
  end

  assign rec_vld  = rec_vld_q;
  assign rec_ch   = rec_ch_q;
  assign rec_opes = rec_q.opes;
  assign rec_cfg  = rec_q.cfg;
  assign rec_tag  = rec_q.tag;
  assign rec_addr = rec_q.addr;

endmodule
